timer_counter: RTL

//  Memory-mapped down-counting timer on the CPU peripheral bus; its IRQ feeds HWInt[0] of the coprocessor-0 interrupt unit.
//  Bus-programmable preset, prescaler, one-shot or auto-reload mode, and an interrupt mask.

---
 rtl/timer_counter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/timer_counter.sv
// Bus-mapped down-counting timer with prescaler,
// one-shot / auto-reload modes and a maskable IRQ.
module timer_counter #(
  parameter int PRESCALE_W     = 16,
  parameter int RESET_PRESCALE = 0
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] A,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

  localparam logic [PRESCALE_W-1:0] RST_PS =
    PRESCALE_W'(RESET_PRESCALE);

  state_t                state_q, state_d;
  logic [3:0]            ctrl_q, ctrl_d;
  logic [31:0]           preset_q, preset_d;
  logic [31:0]           count_q, count_d;
  logic [PRESCALE_W-1:0] ps_q, ps_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  pend_q, pend_d;

  logic wr_ctrl;
  logic wr_preset;
  logic wr_ps;
  logic en;
  logic auto_rl;
  logic tick;
  logic unused_bits;

  assign unused_bits = ^{A[31:4], A[1:0]};

  always_comb begin
    wr_ctrl   = 1'b0;
    wr_preset = 1'b0;
    wr_ps     = 1'b0;
    if (WE) begin
      unique case (A[3:2])
        2'd0:    wr_ctrl   = 1'b1;
        2'd1:    wr_preset = 1'b1;
        2'd3:    wr_ps     = 1'b1;
        default: ;
      endcase
    end
  end

  assign en      = ctrl_q[0];
  assign auto_rl = (ctrl_q[2:1] == 2'b01);
  assign tick    = (state_q == CNT) &&
                   (pcnt_q == ps_q);

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    ps_d     = ps_q;
    pcnt_d   = '0;
    pend_d   = pend_q;

    unique case (state_q)
      IDLE: begin
        if (en) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (tick) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d = '0;
            pend_d  = 1'b1;
            state_d = INT;
          end
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      INT: begin
        if (auto_rl) begin
          pend_d  = 1'b0;
          state_d = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus writes to CTRL/PRESET restart the timer from IDLE.
    if (wr_ctrl || wr_preset) begin
      state_d = IDLE;
      count_d = count_q;
      pcnt_d  = '0;
      pend_d  = 1'b0;
      if (wr_ctrl)   ctrl_d   = Din[3:0];
      if (wr_preset) preset_d = Din;
    end

    if (wr_ps) begin
      ps_d   = Din[PRESCALE_W-1:0];
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      ps_q     <= RST_PS;
      pcnt_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      ps_q     <= ps_d;
      pcnt_q   <= pcnt_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    unique case (A[3:2])
      2'd0:    Dout = {28'd0, ctrl_q};
      2'd1:    Dout = preset_q;
      2'd2:    Dout = count_q;
      default: Dout = 32'(ps_q);
    endcase
  end

  assign IRQ = pend_q & ctrl_q[3];

endmodule
